// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer sitting directly upstream of the datapath.
//
// It fetches 32-bit instructions into an IR over a req/ack port. From the IR it
// decodes the register addresses, ALU controls and sign-extended immediate for
// the datapath. It runs loads to data memory through a memory data register
// (MDR) and resolves BZ/JMP from the datapath's rs value.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   imem_req/addr/ack/rdata instruction fetch handshake (addr = pc)
//   dmem_req/addr/ack/rdata load handshake (addr = latched ALU result)
//   alu_result, rs_val      datapath feedback, sampled in EXEC
//   rs_addr/rt_addr/rd_addr register addresses decoded from IR
//   wrReg, m_to_reg         register-file write enable / select load data
//   mem_data                MDR, goes to the datapath's mem_data_in
//   alu_control, alu_src    ALU op and operand select (1 = rt, 0 = imm)
//   imm_ext                 sign-extended IR[15:0]
//   pc, halted, illegal     current PC and halt status
//   retired                 count of retired instructions
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | one cycle after reset, then start fetching
// FETCH  | imem_req high; wait for imem_ack, load IR and bump PC
// DECODE | IR fields settle on the datapath; no side effects
// EXEC   | sample alu_result/rs_val; resolve branches, halt, illegal
// MEM    | dmem_req high; wait for dmem_ack, load MDR
// WB     | one-cycle register write, retire, back to FETCH
// HALT   | absorbing until reset
module multicycle_ctrl #(
   parameter int unsigned PC_W     = 8,
   parameter int unsigned RESET_PC = 0,
   parameter logic [3:0]  ALU_ADD  = 4'd0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic [31:0]     dmem_addr,
   input  logic            dmem_ack,
   input  logic [31:0]     dmem_rdata,
   input  logic [31:0]     alu_result,
   input  logic [31:0]     rs_val,
   output logic [3:0]      rs_addr,
   output logic [3:0]      rt_addr,
   output logic [3:0]      rd_addr,
   output logic            wrReg,
   output logic            m_to_reg,
   output logic [31:0]     mem_data,
   output logic [3:0]      alu_control,
   output logic            alu_src,
   output logic [31:0]     imm_ext,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            illegal,
   output logic [31:0]     retired
);

   localparam logic [3:0] OP_RALU = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_LD   = 4'd2;
   localparam logic [3:0] OP_BZ   = 4'd3;
   localparam logic [3:0] OP_JMP  = 4'd4;
   localparam logic [3:0] OP_NOP  = 4'd5;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] ir;
   logic [3:0]  op;

   // Decode is purely combinational from the IR; the IR only changes on an
   // accepted fetch, so these are stable through DECODE, EXEC, MEM and WB.
   assign op          = ir[31:28];
   assign rs_addr     = ir[27:24];
   assign rt_addr     = ir[23:20];
   assign rd_addr     = ir[19:16];
   assign imm_ext     = {{16{ir[15]}}, ir[15:0]};
   assign alu_control = (op == OP_RALU) ? ir[3:0] : ALU_ADD;
   assign alu_src     = (op == OP_RALU);
   assign imem_addr   = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         ir        <= '0;
         pc        <= PC_RST;
         mem_data  <= '0;
         dmem_addr <= '0;
         retired   <= '0;
         halted    <= 1'b0;
         illegal   <= 1'b0;
         imem_req  <= 1'b0;
         dmem_req  <= 1'b0;
         wrReg     <= 1'b0;
         m_to_reg  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end

            S_FETCH: begin
               // imem_req is always high in FETCH, so an ack is only ever
               // honoured while a request is outstanding.
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  pc       <= pc + PC_ONE;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end

            S_DECODE: begin
               state <= S_EXEC;
            end

            S_EXEC: begin
               case (op)
                  OP_RALU, OP_ADDI: begin
                     wrReg    <= 1'b1;
                     m_to_reg <= 1'b0;
                     state    <= S_WB;
                  end
                  OP_LD: begin
                     dmem_addr <= alu_result;
                     dmem_req  <= 1'b1;
                     state     <= S_MEM;
                  end
                  OP_BZ: begin
                     // pc already points past the branch, so the offset is
                     // relative to the incremented PC and wraps naturally.
                     if (rs_val == 32'd0) begin
                        pc <= pc + imm_ext[PC_W-1:0];
                     end
                     retired  <= retired + 32'd1;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end
                  OP_JMP: begin
                     pc       <= ir[PC_W-1:0];
                     retired  <= retired + 32'd1;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end
                  OP_NOP: begin
                     retired  <= retired + 32'd1;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end
                  OP_HALT: begin
                     retired <= retired + 32'd1;
                     halted  <= 1'b1;
                     state   <= S_HALT;
                  end
                  default: begin
                     // Illegal opcodes stop the machine without retiring.
                     illegal <= 1'b1;
                     halted  <= 1'b1;
                     state   <= S_HALT;
                  end
               endcase
            end

            S_MEM: begin
               if (dmem_ack) begin
                  mem_data <= dmem_rdata;
                  dmem_req <= 1'b0;
                  wrReg    <= 1'b1;
                  m_to_reg <= 1'b1;
                  state    <= S_WB;
               end
            end

            S_WB: begin
               wrReg    <= 1'b0;
               m_to_reg <= 1'b0;
               retired  <= retired + 32'd1;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end

            S_HALT: begin
               state <= S_HALT;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. Stimulus loads small programs into an
// instruction-memory model and pushes the expected fetch addresses, load
// addresses and write-backs into queues; a monitor pops and compares whenever
// the DUT raises imem_req, raises dmem_req or pulses wrReg.
module tb_multicycle_ctrl;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] alu_result;
   logic [31:0] rs_val;
   logic [3:0]  rs_addr;
   logic [3:0]  rt_addr;
   logic [3:0]  rd_addr;
   logic        wrReg;
   logic        m_to_reg;
   logic [31:0] mem_data;
   logic [3:0]  alu_control;
   logic        alu_src;
   logic [31:0] imm_ext;
   logic [7:0]  pc;
   logic        halted;
   logic        illegal;
   logic [31:0] retired;

   multicycle_ctrl #(.PC_W(8), .RESET_PC(0), .ALU_ADD(4'd0)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .alu_result(alu_result), .rs_val(rs_val),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .wrReg(wrReg), .m_to_reg(m_to_reg), .mem_data(mem_data),
      .alu_control(alu_control), .alu_src(alu_src), .imm_ext(imm_ext),
      .pc(pc), .halted(halted), .illegal(illegal), .retired(retired)
   );

   typedef struct {
      int         cyc;
      logic [7:0] addr;
   } fetch_exp_t;

   typedef struct {
      int          cyc;
      logic [3:0]  rd;
      logic        m2r;
      logic [31:0] mdata;
      logic        asrc;
   } wb_exp_t;

   fetch_exp_t  fetch_q[$];
   wb_exp_t     wb_q[$];
   logic [31:0] dmem_q[$];

   logic [31:0] imem [256];
   logic [31:0] regs [16];
   logic        imem_stall;
   logic        force_ack;
   int          dmem_wait;
   logic [31:0] dmem_word;

   int n_checks;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rs,
                                       input logic [3:0] rt, input logic [3:0] rd,
                                       input logic [15:0] imm);
      return {op, rs, rt, rd, imm};
   endfunction

   task automatic exp_fetch(input int c, input logic [7:0] a);
      fetch_exp_t e;
      e.cyc  = c;
      e.addr = a;
      fetch_q.push_back(e);
   endtask

   task automatic exp_wb(input int c, input logic [3:0] rd, input logic m2r,
                         input logic [31:0] md, input logic asrc);
      wb_exp_t e;
      e.cyc   = c;
      e.rd    = rd;
      e.m2r   = m2r;
      e.mdata = md;
      e.asrc  = asrc;
      wb_q.push_back(e);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responders and a minimal ADD-only datapath model.
   initial begin
      int          dcnt;
      logic [31:0] alu_v;
      dcnt = 0;
      forever begin
         @(negedge clk);
         alu_v      = regs[rs_addr] + (alu_src ? regs[rt_addr] : imm_ext);
         alu_result = alu_v;
         rs_val     = regs[rs_addr];
         if (wrReg && !reset) regs[rd_addr] = m_to_reg ? mem_data : alu_v;
         imem_rdata = imem[imem_addr];
         imem_ack   = force_ack || (imem_req && !imem_stall);
         if (dmem_req) begin
            if (dcnt >= dmem_wait) begin
               dmem_ack   = 1'b1;
               dmem_rdata = dmem_word;
            end else begin
               dmem_ack = 1'b0;
               dcnt++;
            end
         end else begin
            dmem_ack = 1'b0;
            dcnt     = 0;
         end
      end
   end

   // Monitor: cyc counts rising edges since reset release (cyc 1 = first FETCH).
   initial begin
      int         cyc;
      logic       ireq_prev;
      logic       dreq_prev;
      fetch_exp_t fe;
      wb_exp_t    we;
      logic [31:0] da;
      cyc = 0;
      ireq_prev = 1'b0;
      dreq_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cyc       = 0;
            ireq_prev = 1'b0;
            dreq_prev = 1'b0;
         end else begin
            cyc++;
            if (imem_req && !ireq_prev) begin
               if (fetch_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_fetch actual_addr=%h cyc=%0d required=none", imem_addr, cyc);
               end else begin
                  fe = fetch_q.pop_front();
                  chk("fetch_addr", {24'd0, imem_addr}, {24'd0, fe.addr});
                  chk("fetch_cycle", cyc, fe.cyc);
               end
            end
            if (dmem_req && !dreq_prev) begin
               if (dmem_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_dmem_req actual_addr=%h required=none", dmem_addr);
               end else begin
                  da = dmem_q.pop_front();
                  chk("dmem_addr", dmem_addr, da);
               end
            end
            if (wrReg) begin
               if (wb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_wb actual_rd=%h cyc=%0d required=none", rd_addr, cyc);
               end else begin
                  we = wb_q.pop_front();
                  chk("wb_cycle", cyc, we.cyc);
                  chk("wb_rd", {28'd0, rd_addr}, {28'd0, we.rd});
                  chk("wb_m_to_reg", {31'd0, m_to_reg}, {31'd0, we.m2r});
                  chk("wb_alu_src", {31'd0, alu_src}, {31'd0, we.asrc});
                  chk("wb_alu_control", {28'd0, alu_control}, 32'd0);
                  if (we.m2r) chk("wb_mem_data", mem_data, we.mdata);
               end
            end
            ireq_prev = imem_req;
            dreq_prev = dmem_req;
         end
      end
   end

   task automatic start_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
      for (int i = 0; i < 16; i++) regs[i] = 32'd0;
      imem_stall = 1'b0;
      force_ack  = 1'b0;
      dmem_wait  = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run_until_halt(input int max_cyc);
      int n;
      n = 0;
      while (!halted && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (!halted) begin
         n_checks++;
         n_fail++;
         $display("FAIL halt_timeout actual_halted=0 required=1 within %0d cycles", max_cyc);
      end
      repeat (6) @(negedge clk);
      chk("fetch_q_drained", fetch_q.size(), 0);
      chk("wb_q_drained", wb_q.size(), 0);
      chk("dmem_q_drained", dmem_q.size(), 0);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      alu_result = '0;
      rs_val     = '0;
      dmem_word  = 32'hDEAD_BEEF;
      for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
      for (int i = 0; i < 16; i++) regs[i] = 32'd0;
      imem_stall = 1'b0;
      force_ack  = 1'b0;
      dmem_wait  = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pc", {24'd0, pc}, 32'd0);
      chk("rst_reqs", {30'd0, imem_req, dmem_req}, 32'd0);
      chk("rst_wb", {30'd0, wrReg, m_to_reg}, 32'd0);
      chk("rst_status", {30'd0, halted, illegal}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_mdr", mem_data, 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);

      // ADDI r1,r0,5 ; add r2,r1,r1 ; HALT  (zero-wait)
      imem[0] = enc(4'd1, 4'd0, 4'd0, 4'd1, 16'd5);
      imem[1] = enc(4'd0, 4'd1, 4'd1, 4'd2, 16'h0000);
      exp_fetch(1, 8'd0);
      exp_wb(4, 4'd1, 1'b0, 32'd0, 1'b0);
      exp_fetch(5, 8'd1);
      exp_wb(8, 4'd2, 1'b0, 32'd0, 1'b1);
      exp_fetch(9, 8'd2);
      release_reset();
      repeat (9) @(negedge clk);
      chk("alu_retired_after_two", retired, 32'd2);
      run_until_halt(100);
      chk("alu_r2", regs[2], 32'd10);
      chk("alu_retired", retired, 32'd3);
      chk("alu_halt_status", {30'd0, halted, illegal}, 32'b10);

      // ADDI r1,r0,0x100 ; LD r3,[r1+4] with 3-cycle dmem delay ; HALT
      start_reset();
      imem[0]   = enc(4'd1, 4'd0, 4'd0, 4'd1, 16'h0100);
      imem[1]   = enc(4'd2, 4'd1, 4'd0, 4'd3, 16'd4);
      dmem_wait = 3;
      exp_fetch(1, 8'd0);
      exp_wb(4, 4'd1, 1'b0, 32'd0, 1'b0);
      exp_fetch(5, 8'd1);
      dmem_q.push_back(32'h0000_0104);
      exp_wb(12, 4'd3, 1'b1, 32'hDEAD_BEEF, 1'b0);
      exp_fetch(13, 8'd2);
      release_reset();
      run_until_halt(100);
      chk("ld_r3", regs[3], 32'hDEAD_BEEF);
      chk("ld_mdr", mem_data, 32'hDEAD_BEEF);
      chk("ld_retired", retired, 32'd3);

      // JMP 10 ; BZ r2,-2 at 10 taken -> 9 ; ADDI r2,r0,1 ; BZ not taken -> 11 ; HALT
      start_reset();
      imem[0]  = enc(4'd4, 4'd0, 4'd0, 4'd0, 16'h000A);
      imem[10] = enc(4'd3, 4'd2, 4'd0, 4'd0, 16'hFFFE);
      imem[9]  = enc(4'd1, 4'd0, 4'd0, 4'd2, 16'd1);
      exp_fetch(1, 8'd0);
      exp_fetch(4, 8'd10);
      exp_fetch(7, 8'd9);
      exp_wb(10, 4'd2, 1'b0, 32'd0, 1'b0);
      exp_fetch(11, 8'd10);
      exp_fetch(14, 8'd11);
      release_reset();
      run_until_halt(100);
      chk("bz_retired", retired, 32'd5);
      chk("bz_pc", {24'd0, pc}, 32'd12);

      // BZ r1,+3 taken -> 4 ; ADDI r1 ; JMP FF ; NOP at FF wraps to 0 ; BZ not taken ; HALT
      start_reset();
      imem[0]   = enc(4'd3, 4'd1, 4'd0, 4'd0, 16'd3);
      imem[4]   = enc(4'd1, 4'd0, 4'd0, 4'd1, 16'd1);
      imem[5]   = enc(4'd4, 4'd0, 4'd0, 4'd0, 16'h00FF);
      imem[255] = 32'h5000_0000;
      exp_fetch(1, 8'd0);
      exp_fetch(4, 8'd4);
      exp_wb(7, 4'd1, 1'b0, 32'd0, 1'b0);
      exp_fetch(8, 8'd5);
      exp_fetch(11, 8'hFF);
      exp_fetch(14, 8'd0);
      exp_fetch(17, 8'd1);
      release_reset();
      run_until_halt(100);
      chk("wrap_retired", retired, 32'd6);
      chk("wrap_pc", {24'd0, pc}, 32'd2);

      // NOP ; illegal op 0xA -> halted+illegal, no further fetches
      start_reset();
      imem[0] = 32'h5000_0000;
      imem[1] = 32'hA000_0000;
      exp_fetch(1, 8'd0);
      exp_fetch(4, 8'd1);
      release_reset();
      run_until_halt(100);
      repeat (10) @(negedge clk);
      chk("ill_status", {30'd0, halted, illegal}, 32'b11);
      chk("ill_retired", retired, 32'd1);
      chk("ill_no_req", {31'd0, imem_req}, 32'd0);

      // Reset while FETCH is stalled; then ack held high through reset and IDLE
      start_reset();
      imem[0]    = 32'hF000_0000;
      imem[1]    = 32'hA000_0000;
      imem_stall = 1'b1;
      exp_fetch(1, 8'd0);
      release_reset();
      repeat (5) @(negedge clk);
      chk("stall_req_held", {31'd0, imem_req}, 32'd1);
      #2 reset = 1'b1;
      force_ack = 1'b1;
      #1 chk("mid_reset_req_drop", {31'd0, imem_req}, 32'd0);
      chk("mid_reset_fetch_q", fetch_q.size(), 0);
      repeat (2) @(negedge clk);
      exp_fetch(1, 8'd0);
      release_reset();
      run_until_halt(100);
      chk("postrst_status", {30'd0, halted, illegal}, 32'b10);
      chk("postrst_retired", retired, 32'd1);
      chk("postrst_pc", {24'd0, pc}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
